// File: rtl/hello_tx_serializer.sv
// +-----------------------------------------------------------------------+
// | hello_tx_serializer: byte FIFO feeding an 8N1 async serial line.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module hello_tx_serializer #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                         clock,
  input  logic                         io_rst,
  input  logic                         io_in_valid,
  input  logic [7:0]                   io_in_bits,
  output logic                         io_in_ready,
  output logic                         io_tx,
  output logic                         io_busy,
  output logic [$clog2(DEPTH+1)-1:0]   io_count,
  output logic                         io_overflow
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam int c_TW = $clog2(CLKS_PER_BIT);
  localparam logic [c_CW-1:0] c_FULL  = c_CW'(DEPTH);
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]      r_mem [DEPTH];
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic [c_TW-1:0] r_timer;
  logic [2:0]      r_index;
  logic [7:0]      r_shift;
  state_t          r_state;
  logic            r_tx;
  logic            r_busy;
  logic            r_overflow;

  logic w_push;
  logic w_pop;
  logic w_bit_end;

  // Ready depends only on registered occupancy: a same-edge pop never frees a full slot.
  assign io_in_ready = (r_count != c_FULL);
  assign w_push      = io_in_valid && io_in_ready;
  assign w_bit_end   = (r_timer == c_TLAST);
  assign w_pop       = (r_count != '0) &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign io_tx       = r_tx;
  assign io_busy     = r_busy;
  assign io_count    = r_count;
  assign io_overflow = r_overflow;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= io_in_bits;
    end
  end

  always_ff @(posedge clock or posedge io_rst) begin
    if (io_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_timer    <= '0;
      r_index    <= '0;
      r_shift    <= '0;
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;

      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end

      if (io_in_valid && !io_in_ready) r_overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_timer <= '0;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_index <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (r_index == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_index <= r_index + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_timer <= '0;
            // Chain straight into the next start bit so queued frames abut.
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
